// File: rtl/lp_filter_pkg.sv
// Shared definitions for the lp_filter_chain low-pass cascade: parameter bounds,
// width helpers and the per-stage operation encoding.
package lp_filter_pkg;

    localparam int MAX_STAGES      = 8;
    localparam int MAX_SHIFT_LIMIT = 16;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_FILTER,
        OP_RESCALE,
        OP_PRELOAD
    } stage_op_t;

    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rest > 0) begin
                result++;
                rest = rest >> 1;
            end
        end
        return result;
    endfunction

    // Width of a shift field able to hold 0..max_shift
    function automatic int shift_width(input int max_shift);
        return clog2(max_shift + 1);
    endfunction

endpackage

// File: rtl/lp_filter_chain_stage.sv
// One first-order exponential low-pass section: acc += x - (acc >> shift),
// with rescale and preload operations plus a valid flag that travels with the sample.
module lp_filter_chain_stage
    import lp_filter_pkg::*;
#(
    parameter  int DATA_BITS = 28,
    parameter  int MAX_SHIFT = 8,
    localparam int SW        = shift_width(MAX_SHIFT),
    localparam int ACC_W     = DATA_BITS + MAX_SHIFT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] x,
    input  logic [SW-1:0]        shift,
    input  logic                 rescale,
    input  logic [SW-1:0]        old_shift,
    input  logic                 preload,
    output logic [DATA_BITS-1:0] y,
    output logic                 out_valid
);

    logic [ACC_W-1:0]            acc;
    logic signed [DATA_BITS:0]   diff;
    logic [ACC_W-1:0]            diff_ext;
    stage_op_t                   op;

    // old_shift is the shift in force; shift is the rescale/preload target
    assign y = DATA_BITS'(acc >> old_shift);

    always_comb begin
        diff     = $signed({1'b0, x}) - $signed({1'b0, y});
        diff_ext = ACC_W'(diff);
        op       = OP_HOLD;
        if (ce) begin
            if (rescale)
                op = OP_RESCALE;
            else if (preload)
                op = OP_PRELOAD;
            else if (in_valid)
                op = OP_FILTER;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (op)
                OP_HOLD:    acc <= acc;
                OP_FILTER:  acc <= acc + diff_ext;
                OP_RESCALE: acc <= (acc >> old_shift) << shift;
                OP_PRELOAD: acc <= ACC_W'(x) << shift;
            endcase
            // A rescale cycle is a data stall, so the valid flag holds
            if (ce && !rescale)
                out_valid <= in_valid;
        end
    end

endmodule

// File: rtl/lp_filter_chain.sv
// Cascade of STAGES exponential low-pass sections with valid/ready handshake and
// run-time shift changes. Optional macro LP_FILTER_CHAIN_PRELOAD_EN seeds the accumulators.
module lp_filter_chain
    import lp_filter_pkg::*;
#(
    parameter  int DATA_BITS     = 28,
    parameter  int STAGES        = 2,
    parameter  int MAX_SHIFT     = 8,
    parameter  int DEFAULT_SHIFT = 2,
    localparam int SW            = shift_width(MAX_SHIFT)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CE,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [DATA_BITS-1:0] IN_VALUE,
    input  logic                 SHIFT_LOAD,
    input  logic [SW-1:0]        SHIFT_VALUE,
    output logic [SW-1:0]        SHIFT_CUR,
    output logic                 OUT_VALID,
    output logic [DATA_BITS-1:0] OUT_VALUE
);

    localparam bit PARAMS_OK = (STAGES >= 1) && (STAGES <= MAX_STAGES) &&
                               (MAX_SHIFT >= 1) && (MAX_SHIFT <= MAX_SHIFT_LIMIT) &&
                               (DEFAULT_SHIFT >= 0) && (DEFAULT_SHIFT <= MAX_SHIFT);

    assert property (@(posedge CLK) PARAMS_OK);

    logic                             rescale;
    logic [SW-1:0]                    shift_new;
    logic [SW-1:0]                    shift_target;
    logic                             preload;
    logic [STAGES-1:0][DATA_BITS-1:0] stage_x;
    logic [STAGES-1:0][DATA_BITS-1:0] stage_y;
    logic [STAGES-1:0]                stage_iv;
    logic [STAGES-1:0]                stage_ov;

    assign rescale      = CE & SHIFT_LOAD;
    assign shift_new    = (SHIFT_VALUE > SW'(MAX_SHIFT)) ? SW'(MAX_SHIFT) : SHIFT_VALUE;
    assign shift_target = rescale ? shift_new : SHIFT_CUR;

    assign IN_READY  = ~SHIFT_LOAD;
    assign OUT_VALID = stage_ov[STAGES-1] & CE & ~SHIFT_LOAD;
    assign OUT_VALUE = stage_y[STAGES-1];

    always_ff @(posedge CLK) begin
        if (RESET)
            SHIFT_CUR <= SW'(DEFAULT_SHIFT);
        else if (rescale)
            SHIFT_CUR <= shift_new;
    end

`ifdef LP_FILTER_CHAIN_PRELOAD_EN
    logic accept;
    logic preload_armed;

    assign accept  = CE & IN_VALID & ~SHIFT_LOAD;
    assign preload = accept & preload_armed;

    // Only reset re-arms the preload; shift changes leave it spent
    always_ff @(posedge CLK) begin
        if (RESET)
            preload_armed <= 1'b1;
        else if (accept)
            preload_armed <= 1'b0;
    end
`else
    assign preload = 1'b0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_x[k]  = IN_VALUE;
            assign stage_iv[k] = IN_VALID;
        end else begin : g_next
            // During a preload every stage is seeded with the raw sample
            assign stage_x[k]  = preload ? IN_VALUE : stage_y[k-1];
            assign stage_iv[k] = stage_ov[k-1];
        end

        lp_filter_chain_stage #(
            .DATA_BITS (DATA_BITS),
            .MAX_SHIFT (MAX_SHIFT)
        ) u_stage (
            .clk       (CLK),
            .reset     (RESET),
            .ce        (CE),
            .in_valid  (stage_iv[k]),
            .x         (stage_x[k]),
            .shift     (shift_target),
            .rescale   (rescale),
            .old_shift (SHIFT_CUR),
            .preload   (preload),
            .y         (stage_y[k]),
            .out_valid (stage_ov[k])
        );
    end

endmodule
